// File: rtl/fb_mem_pkg.sv
// rtl/fb_mem_pkg.sv - shared types and constants for the framebuffer memory arbiter
package fb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int REQ_VGA  = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_ALG  = 2;
  localparam int NUM_REQ  = 3;

  // 320x240 visible pixels; anything at or above is outside the framebuffer
  localparam int FB_PIXELS = 76800;

  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MEM_LATENCY = 3;
  localparam int DEF_VGA_MAX     = 4;

endpackage

// File: rtl/fb_arb_select.sv
// rtl/fb_arb_select.sv - combinational winner pick: VGA first unless starved
// others are waiting, then host/algorithm round robin.
module fb_arb_select
  import fb_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ptr_i,
  input  logic               vga_limit_i,
  output logic [NUM_REQ-1:0] winner_o
);

  // ptr_i high means the algorithm engine has the next host/algorithm turn
  always_comb begin
    winner_o = '0;
    if (req_i[REQ_VGA] && !vga_limit_i) begin
      winner_o[REQ_VGA] = 1'b1;
    end else if (req_i[REQ_HOST] && (!req_i[REQ_ALG] || !ptr_i)) begin
      winner_o[REQ_HOST] = 1'b1;
    end else if (req_i[REQ_ALG]) begin
      winner_o[REQ_ALG] = 1'b1;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - three-requester framebuffer RAM arbiter with one
// outstanding access, fixed read latency and out-of-range address suppression.
module fb_mem_arbiter
  import fb_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int VGA_MAX     = DEF_VGA_MAX
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wren,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int          VCNT_W   = $clog2(VGA_MAX + 1);
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     win_q;
  logic                   we_q, oob_q, ptr_q;
  logic [VCNT_W-1:0]      vcnt_q;
  logic [2:0]             wcnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q, rdata_q;

  logic [NUM_REQ-1:0]     winner;
  logic                   vga_limit, others_pending, grant_now, last_wait;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_we;

  assign others_pending = req[REQ_HOST] || req[REQ_ALG];
  assign vga_limit      = (vcnt_q == VCNT_W'(VGA_MAX)) && others_pending;
  assign grant_now      = (state_q == IDLE) && (|req);
  assign last_wait      = (state_q == WAIT) && (wcnt_q == LAT_LAST);

  fb_arb_select u_select (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .vga_limit_i (vga_limit),
    .winner_o    (winner)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // VGA is read-only, so its we bit never reaches the latch
  assign sel_we = |(winner & we & 3'b110);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wcnt_q == LAT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      we_q    <= 1'b0;
      oob_q   <= 1'b0;
      ptr_q   <= 1'b0;
      vcnt_q  <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        win_q   <= winner;
        we_q    <= sel_we;
        oob_q   <= (32'(sel_addr) >= 32'(FB_PIXELS));
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        if (!winner[REQ_VGA]) ptr_q <= winner[REQ_HOST];
      end
      if (!others_pending) begin
        vcnt_q <= '0;
      end else if (grant_now) begin
        vcnt_q <= winner[REQ_VGA] ? vcnt_q + VCNT_W'(1) : '0;
      end
      if (state_q == ISSUE) begin
        wcnt_q <= '0;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q + 3'd1;
      end
      if (last_wait && !we_q) rdata_q <= oob_q ? '0 : mem_rdata;
    end
  end

  assign gnt       = (state_q == ISSUE) ? win_q : '0;
  assign done      = (state_q == DONE) ? win_q : '0;
  assign mem_wren  = (state_q == ISSUE) && we_q && !oob_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
